radix_display_ctrl: RTL and testbench

RADIX_DISPLAY_CTRL -- requirements
Module: radix_display_ctrl

---
 rtl/radix_display_ctrl_if.sv | 33 +++
 rtl/radix_display_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_radix_display_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/radix_display_ctrl_if.sv
// radix_display_ctrl_if
//   Groups the display controller's data/status signals into one bundle.
//   Signals:
//     in       binary value to display (IN_W bits)
//     mode_btn raw mode-advance button (asynchronous, may bounce)
//     mode     current radix: 00 octal, 01 decimal, 10 hexadecimal
//     seg      7*DIGITS segment lines, digit k at [7k+6:7k], {g,f,e,d,c,b,a}
//     busy     conversion in progress
//     done     one-cycle pulse when seg is refreshed
//     ovf      last converted value did not fit in DIGITS digits
//   Modports: master drives in/mode_btn, slave (the controller) drives the rest.
interface radix_display_ctrl_if #(
  parameter int unsigned IN_W   = 8,
  parameter int unsigned DIGITS = 3
);
  logic [IN_W-1:0]     in;
  logic                mode_btn;
  logic [1:0]          mode;
  logic [7*DIGITS-1:0] seg;
  logic                busy;
  logic                done;
  logic                ovf;

  modport master (
    output in, mode_btn,
    input  mode, seg, busy, done, ovf
  );

  modport slave (
    input  in, mode_btn,
    output mode, seg, busy, done, ovf
  );
endinterface

// File: rtl/radix_display_ctrl.sv
// radix_display_ctrl
//   Converts an unsigned binary input into DIGITS seven-segment digits in
//   octal, decimal or hexadecimal. A debounced button cycles the radix. A new
//   conversion is queued whenever the input or the radix changes.
//   Ports:
//     clk   system clock, rising edge
//     rst   asynchronous active-high reset
//     dbus  radix_display_ctrl_if.slave (in, mode_btn -> mode, seg, busy, done, ovf)
module radix_display_ctrl #(
  parameter int unsigned IN_W    = 8,
  parameter int unsigned DIGITS  = 3,
  parameter int unsigned DEB_CYC = 4
) (
  input logic                 clk,
  input logic                 rst,
  radix_display_ctrl_if.slave dbus
);

  localparam int unsigned QW  = (IN_W > 4) ? IN_W : 4;
  localparam int unsigned DCW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int unsigned DGW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [6:0]  DASH = 7'b1000000;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_UPDATE} state_e;
  typedef enum logic [1:0] {M_OCT = 2'b00, M_DEC = 2'b01, M_HEX = 2'b10} mode_e;

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d, cap_mode_q, cap_mode_d;
  logic                sync1_q, sync2_q;
  logic                deb_q, deb_d, deb_prev_q;
  logic [DCW-1:0]      deb_cnt_q, deb_cnt_d;
  logic                pending_q, pending_d;
  logic [IN_W-1:0]     last_in_q, last_in_d;
  logic [QW-1:0]       quot_q, quot_d;
  logic [4*DIGITS-1:0] dig_q, dig_d;
  logic [DGW-1:0]      div_cnt_q, div_cnt_d;
  logic [7*DIGITS-1:0] seg_q, seg_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic [QW-1:0]       q_div;
  logic [3:0]          rem;
  logic                deb_rise;

  function automatic logic [6:0] font7(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign deb_rise = deb_q & ~deb_prev_q;

  // One division step by the radix captured at LOAD.
  always_comb begin
    q_div = quot_q;
    rem   = '0;
    unique case (cap_mode_q)
      M_OCT: begin
        q_div = quot_q >> 3;
        rem   = {1'b0, quot_q[2:0]};
      end
      M_DEC: begin
        q_div = quot_q / QW'(10);
        rem   = 4'(quot_q % QW'(10));
      end
      default: begin
        q_div = quot_q >> 4;
        rem   = quot_q[3:0];
      end
    endcase
  end

  always_comb begin
    logic [4*DIGITS-1:0] dig_n;
    logic [QW-1:0]       quot_n;
    logic                ovf_n;

    state_d    = state_q;
    mode_d     = mode_q;
    cap_mode_d = cap_mode_q;
    deb_d      = deb_q;
    deb_cnt_d  = '0;
    pending_d  = pending_q;
    last_in_d  = last_in_q;
    quot_d     = quot_q;
    dig_d      = dig_q;
    div_cnt_d  = div_cnt_q;
    seg_d      = seg_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    busy_d     = busy_q;
    dig_n      = dig_q;
    quot_n     = quot_q;
    ovf_n      = 1'b0;

    // Debounce: the synchronised level must differ for DEB_CYC cycles in a row.
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DCW'(DEB_CYC - 1)) begin
        deb_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          state_d = S_LOAD;
          busy_d  = 1'b1;
        end
      end
      S_LOAD: begin
        quot_d     = QW'(dbus.in);
        last_in_d  = dbus.in;
        cap_mode_d = mode_q;
        pending_d  = 1'b0;
        div_cnt_d  = '0;
        dig_d      = '0;
        state_d    = S_DIV;
      end
      S_DIV: begin
        // Digits enter at the top and shift down, so after DIGITS steps the
        // first remainder (least significant digit) sits at digit 0.
        quot_n = q_div;
        dig_n  = dig_q >> 4;
        dig_n[4*DIGITS-4 +: 4] = rem;
        quot_d    = quot_n;
        dig_d     = dig_n;
        div_cnt_d = div_cnt_q + 1'b1;
        if (div_cnt_q == DGW'(DIGITS - 1)) begin
          // Output registers load on the edge into UPDATE so that seg, ovf
          // and done are all presented together during the UPDATE cycle.
          ovf_n  = (quot_n != '0);
          ovf_d  = ovf_n;
          for (int unsigned k = 0; k < DIGITS; k++) begin
            seg_d[7*k +: 7] = ovf_n ? DASH : font7(dig_n[4*k +: 4]);
          end
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_UPDATE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The LOAD edge samples in itself, so a difference is only meaningful
    // outside LOAD; a radix step always requeues, even over LOAD's clear.
    if (state_q != S_LOAD && dbus.in != last_in_q) begin
      pending_d = 1'b1;
    end
    if (deb_rise) begin
      pending_d = 1'b1;
      unique case (mode_q)
        M_OCT:   mode_d = M_DEC;
        M_DEC:   mode_d = M_HEX;
        default: mode_d = M_OCT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_q     <= M_OCT;
      cap_mode_q <= M_OCT;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      deb_cnt_q  <= '0;
      pending_q  <= 1'b1;
      last_in_q  <= '0;
      quot_q     <= '0;
      dig_q      <= '0;
      div_cnt_q  <= '0;
      seg_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cap_mode_q <= cap_mode_d;
      sync1_q    <= dbus.mode_btn;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      deb_cnt_q  <= deb_cnt_d;
      pending_q  <= pending_d;
      last_in_q  <= last_in_d;
      quot_q     <= quot_d;
      dig_q      <= dig_d;
      div_cnt_q  <= div_cnt_d;
      seg_q      <= seg_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign dbus.mode = mode_q;
  assign dbus.seg  = seg_q;
  assign dbus.busy = busy_q;
  assign dbus.done = done_q;
  assign dbus.ovf  = ovf_q;

endmodule

// File: tb/tb_radix_display_ctrl.sv
// tb_radix_display_ctrl
//   Self-checking bench for radix_display_ctrl. Two instances: A with
//   DIGITS=3 and B with DIGITS=2 (overflow cases). Expected displays are
//   pushed to per-instance queues when stimulus is applied and compared
//   whenever the instance pulses done.
module tb_radix_display_ctrl;

  localparam int unsigned IN_W  = 8;
  localparam int unsigned DIG_A = 3;
  localparam int unsigned DIG_B = 2;
  localparam int unsigned DEB   = 4;

  localparam logic [6:0] FONT [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  typedef struct packed {
    logic [41:0] seg;
    logic        ovf;
    logic [1:0]  mode;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  radix_display_ctrl_if #(.IN_W(IN_W), .DIGITS(DIG_A)) ifa ();
  radix_display_ctrl_if #(.IN_W(IN_W), .DIGITS(DIG_B)) ifb ();

  radix_display_ctrl #(.IN_W(IN_W), .DIGITS(DIG_A), .DEB_CYC(DEB)) dut_a (
    .clk  (clk),
    .rst  (rst_a),
    .dbus (ifa.slave)
  );

  radix_display_ctrl #(.IN_W(IN_W), .DIGITS(DIG_B), .DEB_CYC(DEB)) dut_b (
    .clk  (clk),
    .rst  (rst_b),
    .dbus (ifb.slave)
  );

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;
  exp_t ex;
  int   n_checks = 0;
  int   n_err    = 0;
  int   n;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int unsigned val, input logic [1:0] m, input int unsigned nd);
    exp_t        e;
    int unsigned r, v, d;
    r = (m == 2'b00) ? 8 : (m == 2'b01) ? 10 : 16;
    v = val;
    e = '0;
    e.mode = m;
    for (int unsigned k = 0; k < nd; k++) begin
      d = v % r;
      v = v / r;
      e.seg[7*k +: 7] = FONT[d];
    end
    e.ovf = (v != 0);
    if (e.ovf) begin
      for (int unsigned k = 0; k < nd; k++) e.seg[7*k +: 7] = 7'b1000000;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (ifa.done === 1'b1) begin
      if (qa.size() == 0) begin
        check("unexpected_done_a", ifa.done, 1'b0);
      end else begin
        ea = qa.pop_front();
        check("seg_a", ifa.seg, ea.seg);
        check("ovf_a", ifa.ovf, ea.ovf);
        check("mode_a", ifa.mode, ea.mode);
        check("busy_at_done_a", ifa.busy, 1'b0);
      end
    end
  end

  always @(negedge clk) begin
    if (ifb.done === 1'b1) begin
      if (qb.size() == 0) begin
        check("unexpected_done_b", ifb.done, 1'b0);
      end else begin
        eb = qb.pop_front();
        check("seg_b", ifb.seg, eb.seg);
        check("ovf_b", ifb.ovf, eb.ovf);
        check("mode_b", ifb.mode, eb.mode);
      end
    end
  end

  // Counts rising edges until done is seen high at the following falling edge.
  task automatic wait_done(input bit sel_b, input int budget, output int cnt);
    cnt = 0;
    while (cnt < budget) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if ((sel_b ? ifb.done : ifa.done) === 1'b1) return;
    end
    check(sel_b ? "done_timeout_b" : "done_timeout_a", sel_b ? ifb.done : ifa.done, 1'b1);
  endtask

  task automatic press(input bit sel_b);
    if (sel_b) ifb.mode_btn = 1'b1; else ifa.mode_btn = 1'b1;
    repeat (8) @(negedge clk);
    if (sel_b) ifb.mode_btn = 1'b0; else ifa.mode_btn = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] pat;
    ifa.in = 8'd200; ifa.mode_btn = 1'b0;
    ifb.in = 8'd0;   ifb.mode_btn = 1'b0;
    rst_a = 1'b0; rst_b = 1'b0;
    #1;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_seg_a", ifa.seg, '0);
    check("rst_mode_a", ifa.mode, 2'b00);
    check("rst_busy_a", ifa.busy, 1'b0);
    check("rst_done_a", ifa.done, 1'b0);
    check("rst_ovf_a", ifa.ovf, 1'b0);
    check("rst_seg_b", ifb.seg, '0);

    // Release, then change in during the first DIV cycle.
    qa.push_back(model(200, 2'b00, DIG_A));
    rst_a = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_div_a", ifa.busy, 1'b1);
    ifa.in = 8'd7;
    qa.push_back(model(7, 2'b00, DIG_A));
    wait_done(1'b0, 20, n);
    check("first_latency_a", n + 2, DIG_A + 2);
    // From the first done cycle: UPDATE->IDLE, IDLE->LOAD, LOAD, DIGITS DIV steps.
    wait_done(1'b0, 20, n);
    check("redo_latency_a", n, DIG_A + 3);

    repeat (3) @(negedge clk);
    ifa.in = 8'd200;
    qa.push_back(model(200, 2'b00, DIG_A));
    wait_done(1'b0, 20, n);

    // Two clean presses: decimal then hexadecimal.
    qa.push_back(model(200, 2'b01, DIG_A));
    press(1'b0);
    wait_done(1'b0, 60, n);
    repeat (10) @(negedge clk);
    qa.push_back(model(200, 2'b10, DIG_A));
    press(1'b0);
    wait_done(1'b0, 60, n);
    repeat (10) @(negedge clk);

    // Short pulse and bounce: no mode change, no conversion.
    pat = 12'b111000101000;
    for (int i = 11; i >= 0; i--) begin
      ifa.mode_btn = pat[i];
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
    ex = model(200, 2'b10, DIG_A);
    check("bounce_mode_a", ifa.mode, 2'b10);
    check("idle_busy_a", ifa.busy, 1'b0);
    check("idle_seg_a", ifa.seg, ex.seg);

    // Reset in the middle of a conversion.
    ifa.in = 8'd99;
    repeat (4) @(negedge clk);
    check("busy_div2_a", ifa.busy, 1'b1);
    rst_a = 1'b1;
    #1;
    check("mid_rst_seg_a", ifa.seg, '0);
    check("mid_rst_mode_a", ifa.mode, 2'b00);
    check("mid_rst_busy_a", ifa.busy, 1'b0);
    check("mid_rst_done_a", ifa.done, 1'b0);
    check("mid_rst_ovf_a", ifa.ovf, 1'b0);
    repeat (3) @(negedge clk);
    qa.push_back(model(99, 2'b00, DIG_A));
    rst_a = 1'b0;
    wait_done(1'b0, 20, n);
    check("rst_restart_latency_a", n, DIG_A + 2);

    // Instance B: two digits, decimal overflow and recovery.
    qb.push_back(model(0, 2'b00, DIG_B));
    rst_b = 1'b0;
    wait_done(1'b1, 20, n);
    qb.push_back(model(0, 2'b01, DIG_B));
    press(1'b1);
    wait_done(1'b1, 60, n);
    repeat (10) @(negedge clk);
    ifb.in = 8'd255;
    qb.push_back(model(255, 2'b01, DIG_B));
    wait_done(1'b1, 20, n);
    repeat (3) @(negedge clk);
    ifb.in = 8'd99;
    qb.push_back(model(99, 2'b01, DIG_B));
    wait_done(1'b1, 20, n);

    repeat (10) @(negedge clk);
    check("sb_empty_a", 64'(qa.size()), 64'd0);
    check("sb_empty_b", 64'(qb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
